mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 85 ++++++++
 tb/tb_mem_wb_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage with a 256x8 synchronous data RAM that is zeroed by a
// CLEAR sequence after every reset before normal traffic is accepted.
//
// state | meaning
// CLEAR | sweep RAM writing 0x00 to each address, pipeline held as bubble, busy_out=1
// RUN   | normal load/store/writeback operation, busy_out=0
module mem_wb_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] alu_result_in,
    input  logic [7:0] val_rs2_in,
    input  logic [2:0] rd_in,
    input  logic [7:0] mem_addr_in,
    input  logic       we_ram_in,
    input  logic       re_ram_in,
    input  logic       we_rf_in,
    input  logic       stall,
    input  logic       flush,
    output logic [7:0] wb_data_out,
    output logic [2:0] rd_out,
    output logic       we_rf_out,
    output logic       busy_out
);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t     state;
    logic [7:0] clr_cnt;
    logic [7:0] ram [256];
    logic       clear_we;
    logic       store_we;
    logic       is_load;

    assign clear_we = (state == CLEAR) && !rst;
    assign store_we = (state == RUN) && !rst && we_ram_in && !stall && !flush;
    // A simultaneous store wins; the load is dropped and the ALU value is written back.
    assign is_load  = re_ram_in && !we_ram_in;
    assign busy_out = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (clear_we) begin
            ram[clr_cnt] <= 8'h00;
        end else if (store_we) begin
            ram[mem_addr_in] <= val_rs2_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            clr_cnt     <= 8'h00;
            wb_data_out <= 8'h00;
            rd_out      <= 3'd0;
            we_rf_out   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt     <= clr_cnt + 8'd1;
                    wb_data_out <= 8'h00;
                    rd_out      <= 3'd0;
                    we_rf_out   <= 1'b0;
                    if (clr_cnt == 8'hFF) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        wb_data_out <= 8'h00;
                        rd_out      <= 3'd0;
                        we_rf_out   <= 1'b0;
                    end else if (!stall) begin
                        // Read sees the previous cycle's store, giving read-after-write for free.
                        wb_data_out <= is_load ? ram[mem_addr_in] : alu_result_in;
                        rd_out      <= rd_in;
                        we_rf_out   <= we_rf_in;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural model of the stage.
module tb_mem_wb_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_result_in;
    logic [7:0] val_rs2_in;
    logic [2:0] rd_in;
    logic [7:0] mem_addr_in;
    logic       we_ram_in;
    logic       re_ram_in;
    logic       we_rf_in;
    logic       stall;
    logic       flush;
    logic [7:0] wb_data_out;
    logic [2:0] rd_out;
    logic       we_rf_out;
    logic       busy_out;

    int checks = 0;
    int errors = 0;

    mem_wb_stage dut (
        .clk          (clk),
        .rst          (rst),
        .alu_result_in(alu_result_in),
        .val_rs2_in   (val_rs2_in),
        .rd_in        (rd_in),
        .mem_addr_in  (mem_addr_in),
        .we_ram_in    (we_ram_in),
        .re_ram_in    (re_ram_in),
        .we_rf_in     (we_rf_in),
        .stall        (stall),
        .flush        (flush),
        .wb_data_out  (wb_data_out),
        .rd_out       (rd_out),
        .we_rf_out    (we_rf_out),
        .busy_out     (busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory image, remaining clear cycles, expected outputs.
    logic [7:0] m_mem [256];
    int         m_clear_left = 0;
    bit         m_valid = 1'b0;
    logic [7:0] e_wb;
    logic [2:0] e_rd;
    logic       e_we;

    always @(posedge clk) begin
        if (rst) begin
            m_valid      = 1'b1;
            m_clear_left = 256;
            for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
            e_wb = 8'h00; e_rd = 3'd0; e_we = 1'b0;
        end else if (m_valid) begin
            if (m_clear_left > 0) begin
                m_clear_left--;
                e_wb = 8'h00; e_rd = 3'd0; e_we = 1'b0;
            end else if (flush) begin
                e_wb = 8'h00; e_rd = 3'd0; e_we = 1'b0;
            end else if (!stall) begin
                e_wb = (re_ram_in && !we_ram_in) ? m_mem[mem_addr_in] : alu_result_in;
                e_rd = rd_in;
                e_we = we_rf_in;
                if (we_ram_in) m_mem[mem_addr_in] = val_rs2_in;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("wb_data", int'(wb_data_out), int'(e_wb));
            chk("rd", int'(rd_out), int'(e_rd));
            chk("we_rf", int'(we_rf_out), int'(e_we));
            chk("busy", int'(busy_out), (m_clear_left > 0) ? 1 : 0);
        end
    end

    task automatic cyc(input logic r, input logic we, input logic re, input logic [7:0] addr,
                       input logic [7:0] val, input logic [7:0] alu, input logic [2:0] rd,
                       input logic wrf, input logic st, input logic fl);
        rst = r; we_ram_in = we; re_ram_in = re; mem_addr_in = addr;
        val_rs2_in = val; alu_result_in = alu; rd_in = rd; we_rf_in = wrf;
        stall = st; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] addr);
        cyc(1'b0, 1'b0, 1'b1, addr, 8'h00, 8'hEE, 3'd1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic store(input logic [7:0] addr, input logic [7:0] val);
        cyc(1'b0, 1'b1, 1'b0, addr, val, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Releases reset and counts cycles with busy_out high, bounded.
    task automatic release_and_count(input string name);
        int n;
        n = 0;
        rst = 1'b0;
        while (busy_out && n < 1000) begin
            idle();
            n++;
        end
        chk(name, n, 256);
    endtask

    initial begin
        rst = 1'b1; we_ram_in = 0; re_ram_in = 0; mem_addr_in = 0; val_rs2_in = 0;
        alu_result_in = 0; rd_in = 0; we_rf_in = 0; stall = 0; flush = 0;
        @(posedge clk); #1;

        // Reset clear
        cyc(1'b1, 1'b1, 1'b0, 8'h05, 8'h77, 8'h12, 3'd3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 8'h77, 8'h12, 3'd3, 1'b1, 1'b0, 1'b0);
        chk("rst_busy", int'(busy_out), 1);
        chk("rst_wb", int'(wb_data_out), 0);
        release_and_count("clear_len");
        load(8'h00); chk("clr_ld00", int'(wb_data_out), 8'h00);
        load(8'h05); chk("clr_ld05", int'(wb_data_out), 8'h00);
        load(8'hFF); chk("clr_ldFF", int'(wb_data_out), 8'h00);

        // Store then load
        store(8'h3C, 8'hA5);
        cyc(1'b0, 1'b0, 1'b1, 8'h3C, 8'h00, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0);
        chk("raw_data", int'(wb_data_out), 8'hA5);
        chk("raw_rd", int'(rd_out), 5);
        chk("raw_we", int'(we_rf_out), 1);

        // ALU pass
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h7E, 3'd2, 1'b1, 1'b0, 1'b0);
        chk("alu_data", int'(wb_data_out), 8'h7E);
        chk("alu_rd", int'(rd_out), 2);

        // Stall holds and suppresses store
        cyc(1'b0, 1'b1, 1'b0, 8'h10, 8'h55, 8'h33, 3'd6, 1'b0, 1'b1, 1'b0);
        chk("stall_data", int'(wb_data_out), 8'h7E);
        chk("stall_rd", int'(rd_out), 2);
        load(8'h10); chk("stall_nowr", int'(wb_data_out), 8'h00);

        // Flush over stall
        cyc(1'b0, 1'b1, 1'b0, 8'h11, 8'h66, 8'h44, 3'd3, 1'b1, 1'b1, 1'b1);
        chk("flush_we", int'(we_rf_out), 0);
        chk("flush_rd", int'(rd_out), 0);
        chk("flush_data", int'(wb_data_out), 0);
        load(8'h11); chk("flush_nowr", int'(wb_data_out), 8'h00);

        // Boundary addresses and store+load
        store(8'hFF, 8'hFF);
        store(8'h00, 8'h11);
        load(8'hFF); chk("bnd_ldFF", int'(wb_data_out), 8'hFF);
        load(8'h00); chk("bnd_ld00", int'(wb_data_out), 8'h11);
        cyc(1'b0, 1'b1, 1'b1, 8'hFF, 8'h22, 8'h5A, 3'd4, 1'b1, 1'b0, 1'b0);
        chk("st_ld_alu", int'(wb_data_out), 8'h5A);
        load(8'hFF); chk("st_ld_wr", int'(wb_data_out), 8'h22);

        // Reset mid-CLEAR
        store(8'h20, 8'h99);
        load(8'h20); chk("pre_rst", int'(wb_data_out), 8'h99);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) idle();
        chk("mid_busy", int'(busy_out), 1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        release_and_count("mid_clear_len");
        load(8'h20); chk("mid_ld20", int'(wb_data_out), 8'h00);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            cyc(($urandom_range(0, 599) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 1) == 0),
                a, 8'($urandom), 8'($urandom), 3'($urandom),
                1'($urandom),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
